// File: rtl/delay_line.sv
// Multi-channel RAM-backed sample delay line with run-time delay, priming/valid tracking and flush.
// Latency: output registered one edge after the accepting ce; data_o is the sample pushed dly_o pushes earlier.
// Backpressure: none; ce gates all progress, ce=0 holds every state bit and output.
module delay_line #(
    parameter int DATA_WIDTH  = 25,
    parameter int CHANNELS    = 1,
    parameter int MAX_LEN     = 512,
    parameter int DEFAULT_DLY = MAX_LEN
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ce,
    input  logic                                clr,
    input  logic                                dly_ld,
    input  logic [$clog2(MAX_LEN+1)-1:0]        dly_i,
    input  logic [DATA_WIDTH*CHANNELS-1:0]      di,
    output logic [DATA_WIDTH*CHANNELS-1:0]      data_o,
    output logic                                valid_o,
    output logic [$clog2(MAX_LEN+1)-1:0]        dly_o,
    output logic                                cfg_err_o
);

    // Pointer and delay share one width; depth is a power of two strictly above
    // MAX_LEN, so pointer wrap is free and the read never hits the write slot.
    localparam int AW    = $clog2(MAX_LEN + 1);
    localparam int DEPTH = 1 << AW;
    localparam int DW    = DATA_WIDTH * CHANNELS;

    localparam logic [AW-1:0] MAX_L   = AW'(MAX_LEN);
    localparam logic [AW-1:0] DEF_DLY = AW'(DEFAULT_DLY);

    // All lanes are stored side by side in one word, so lanes never mix.
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q,  wptr_d;
    logic [AW-1:0] fill_q,  fill_d;
    logic [AW-1:0] dly_q,   dly_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          err_q,   err_d;

    logic          dly_ok;
    logic          wr_en;
    logic [AW-1:0] raddr;

    // Next-state logic: clr beats dly_ld beats ce.
    always_comb begin
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        dly_d   = dly_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        dly_ok  = (dly_i != '0) && (dly_i <= MAX_L);
        // The sample leaving the line was written dly_q slots behind the current write slot.
        raddr   = wptr_q - dly_q;

        if (clr) begin
            // Flush drops any concurrent sample and load.
            wptr_d  = '0;
            fill_d  = '0;
            valid_d = 1'b0;
            data_d  = '0;
            err_d   = 1'b0;
        end else if (dly_ld && dly_ok) begin
            // New delay restarts priming; a concurrent sample is the first one under it.
            dly_d   = dly_i;
            fill_d  = '0;
            valid_d = 1'b0;
            data_d  = '0;
            if (ce) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + 1'b1;
                fill_d = AW'(1);
            end
        end else begin
            // An illegal load only raises the sticky error; the stream carries on.
            if (dly_ld) begin
                err_d = 1'b1;
            end
            if (ce) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + 1'b1;
                // fill saturated at the delay means at least dly_q samples precede this one.
                if (fill_q >= dly_q) begin
                    valid_d = 1'b1;
                    data_d  = mem[raddr];
                end else begin
                    fill_d  = fill_q + 1'b1;
                    valid_d = 1'b0;
                    data_d  = '0;
                end
            end
        end
    end

    // Sample storage; contents deliberately survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= di;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            fill_q  <= '0;
            dly_q   <= DEF_DLY;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            dly_q   <= dly_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign dly_o     = dly_q;
    assign cfg_err_o = err_q;

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: directed vector table, asynchronous reset sequence, random run vs. queue model.
// Latency: each row/cycle is checked 1 time unit after the edge that consumed it.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_delay_line;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int ML = 16;
    localparam int DD = 4;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          clr;
    logic          dly_ld;
    logic [LW-1:0] dly_i;
    logic [15:0]   di;
    logic [15:0]   data_o;
    logic          valid_o;
    logic [LW-1:0] dly_o;
    logic          cfg_err_o;

    int passed = 0;
    int total  = 0;

    delay_line #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .MAX_LEN    (ML),
        .DEFAULT_DLY(DD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .clr      (clr),
        .dly_ld   (dly_ld),
        .dly_i    (dly_i),
        .di       (di),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .dly_o    (dly_o),
        .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ce;
        logic          clr;
        logic          ld;
        logic [LW-1:0] dly;
        int            k;
        logic          ev;
        logic [15:0]   ed;
        logic [LW-1:0] edly;
        logic          eerr;
    } vec_t;

    vec_t tbl[$];

    // k-th pushed sample: ch0 = k, ch1 = 0x80 + k.
    function automatic logic [15:0] smp(input int k);
        logic [7:0] c0;
        logic [7:0] c1;
        c0 = 8'(k);
        c1 = 8'(128 + k);
        return {c1, c0};
    endfunction

    function automatic void add(input logic c, input logic cl, input logic ld, input int dly,
                                input int k, input logic ev, input logic [15:0] ed,
                                input int edly, input logic eerr);
        vec_t v;
        v.ce = c; v.clr = cl; v.ld = ld; v.dly = LW'(dly); v.k = k;
        v.ev = ev; v.ed = ed; v.edly = LW'(edly); v.eerr = eerr;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [15:0] ed,
                           input logic [LW-1:0] edly, input logic eerr);
        chk({tag, " valid"}, 32'(valid_o),   32'(ev));
        chk({tag, " data"},  32'(data_o),    32'(ed));
        chk({tag, " dly"},   32'(dly_o),     32'(edly));
        chk({tag, " err"},   32'(cfg_err_o), 32'(eerr));
    endtask

    task automatic drive(input logic c, input logic cl, input logic ld,
                         input logic [LW-1:0] d, input logic [15:0] x);
        ce = c; clr = cl; dly_ld = ld; dly_i = d; di = x;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: queue of samples accepted since the last restart.
    logic [15:0] hist[$];
    int          mcnt;
    int          mdly;
    logic        merr;
    logic        mv;
    logic [15:0] md;

    task automatic model_step(input logic c, input logic cl, input logic ld,
                              input logic [LW-1:0] d, input logic [15:0] x);
        if (cl) begin
            hist.delete(); mcnt = 0; mv = 0; md = '0; merr = 0;
        end else if (ld && d >= 1 && d <= ML) begin
            mdly = int'(d); hist.delete(); mcnt = 0; mv = 0; md = '0;
            if (c) begin
                hist.push_back(x); mcnt = 1;
            end
        end else begin
            if (ld) merr = 1;
            if (c) begin
                hist.push_back(x);
                mcnt++;
                if (mcnt - 1 >= mdly) begin
                    mv = 1;
                    md = hist[hist.size() - 1 - mdly];
                end else begin
                    mv = 0;
                    md = '0;
                end
                while (hist.size() > ML + 1) void'(hist.pop_front());
            end
        end
    endtask

    initial begin
        logic        rc;
        logic        rcl;
        logic        rld;
        logic [LW-1:0] rd;
        logic [15:0] rx;

        // Directed table built from the expected delay arithmetic.
        for (int k = 1; k <= 10; k++)
            add(1, 0, 0, 0, k, k >= 5, (k >= 5) ? smp(k - 4) : 16'h0, 4, 0);
        add(0, 1, 0, 0, 0, 0, 16'h0, 4, 0);
        for (int k = 1; k <= 10; k++) begin
            add(1, 0, 0, 0, k, k >= 5, (k >= 5) ? smp(k - 4) : 16'h0, 4, 0);
            add(0, 0, 0, 0, 99, k >= 5, (k >= 5) ? smp(k - 4) : 16'h0, 4, 0);
        end
        add(1, 0, 1, 16, 11, 0, 16'h0, 16, 0);
        for (int k = 12; k <= 30; k++)
            add(1, 0, 0, 0, k, k >= 27, (k >= 27) ? smp(k - 16) : 16'h0, 16, 0);
        add(1, 0, 1, 1, 31, 0, 16'h0, 1, 0);
        for (int k = 32; k <= 36; k++)
            add(1, 0, 0, 0, k, 1, smp(k - 1), 1, 0);
        add(1, 0, 1, 4, 37, 0, 16'h0, 4, 0);
        for (int k = 38; k <= 45; k++)
            add(1, 0, 0, 0, k, k >= 41, (k >= 41) ? smp(k - 4) : 16'h0, 4, 0);
        add(1, 0, 1, 0, 46, 1, smp(42), 4, 1);
        add(1, 0, 1, 17, 47, 1, smp(43), 4, 1);
        add(1, 0, 0, 0, 48, 1, smp(44), 4, 1);
        add(0, 0, 1, 20, 98, 1, smp(44), 4, 1);
        add(1, 1, 1, 8, 49, 0, 16'h0, 4, 0);
        for (int k = 50; k <= 55; k++)
            add(1, 0, 0, 0, k, k >= 54, (k >= 54) ? smp(k - 4) : 16'h0, 4, 0);

        // Reset state.
        rst_n = 1'b0; ce = 0; clr = 0; dly_ld = 0; dly_i = '0; di = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 16'h0, LW'(DD), 1'b0);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ce, tbl[i].clr, tbl[i].ld, tbl[i].dly, smp(tbl[i].k));
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].edly, tbl[i].eerr);
        end

        // Asynchronous reset mid-stream, between edges.
        drive(0, 1, 0, '0, '0);
        drive(1, 0, 1, LW'(3), smp(1));
        drive(0, 0, 1, LW'(0), '0);
        for (int k = 2; k <= 6; k++) drive(1, 0, 0, '0, smp(k));
        chk_all("pre_rst", 1'b1, smp(3), LW'(3), 1'b1);
        ce = 0; dly_ld = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 16'h0, LW'(DD), 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_all("rst_hold", 1'b0, 16'h0, LW'(DD), 1'b0);

        // Random run against the queue model.
        hist.delete(); mcnt = 0; mdly = DD; merr = 0; mv = 0; md = '0;
        for (int i = 0; i < 3000; i++) begin
            rc  = ($urandom_range(0, 9) < 7);
            rcl = ($urandom_range(0, 59) == 0);
            rld = ($urandom_range(0, 24) == 0);
            rd  = LW'($urandom_range(0, 20));
            rx  = 16'($urandom);
            model_step(rc, rcl, rld, rd, rx);
            drive(rc, rcl, rld, rd, rx);
            chk_all($sformatf("rnd%0d", i), mv, md, LW'(mdly), merr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
